seq_mult_param: RTL and testbench

- Parametrised iterative shift-add multiplier; successor to the fixed 8x8 unsigned multiplier behind `top`.
- Adds a configurable operand width, a runtime signed/unsigned mode and a `busy` status output.
- Keeps the start/done handshake, so it drops into the existing top-level slot unchanged apart from width.
- One partial-product bit per cycle, constant latency regardless of operand values.

---
 rtl/seq_mult_param.sv | 141 ++++++++++++++
 tb/tb_seq_mult_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier with a configurable width and optional two's-complement mode.
// Each operation takes WIDTH+3 cycles: capture, WIDTH partial-product steps, sign fix-up, done.
module seq_mult_param #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   d_out,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    dout_q, dout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sgn_s;

    // Next-state and datapath computation for every state.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dout_d   = dout_q;
        done_d   = done_q;
        busy_d   = busy_q;
        sgn_s    = mode_signed & SIGNED_EN;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(a, sgn_s)};
                    mplier_d = magnitude(b, sgn_s);
                    neg_d    = sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = {PW{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                if (neg_q) begin
                    dout_d = ~acc_q + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    dout_d = acc_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            neg_q    <= 1'b0;
            dout_q   <= {PW{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign d_out = dout_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: 8-bit signed, 8-bit unsigned-only and 16-bit instances.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        start8 = 1'b0, startu = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic [15:0] dout8, doutu;
    logic [31:0] dout16;
    logic        done8, doneu, done16, busy8, busyu, busy16;

    int          errors = 0;
    int          checks = 0;
    int          sel_v = 0;
    logic [31:0] dout_sel;
    logic        done_sel, busy_sel;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode_signed(mode), .a(a8), .b(b8),
        .d_out(dout8), .done(done8), .busy(busy8));
    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dutu (
        .clk(clk), .rst(rst), .start(startu), .mode_signed(mode), .a(a8), .b(b8),
        .d_out(doutu), .done(doneu), .busy(busyu));
    seq_mult_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode_signed(mode), .a(a16), .b(b16),
        .d_out(dout16), .done(done16), .busy(busy16));

    always_comb begin
        case (sel_v)
            1:       begin dout_sel = {16'h0000, doutu}; done_sel = doneu;  busy_sel = busyu;  end
            2:       begin dout_sel = dout16;            done_sel = done16; busy_sel = busy16; end
            default: begin dout_sel = {16'h0000, dout8}; done_sel = done8;  busy_sel = busy8;  end
        endcase
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        m;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps until done, checking latency (edges after capture), value, busy and the one-cycle pulse.
    task automatic wait_done(input int sel, input int exp_k, input logic [31:0] exp_v, input string name);
        bit seen = 1'b0;
        int lat = 0;
        sel_v = sel;
        for (int k = 1; k <= 40 && !seen; k++) begin
            step();
            if (k == 1) check({name, " busy"}, {31'd0, busy_sel}, 32'd1);
            if (done_sel) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (seen) begin
            check({name, " latency"}, lat, exp_k);
            check({name, " d_out"}, dout_sel, exp_v);
            check({name, " busy at done"}, {31'd0, busy_sel}, 32'd0);
        end else begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end
        step();
        check({name, " done pulse"}, {31'd0, done_sel}, 32'd0);
    endtask

    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic m,
                          input int exp_k, input logic [31:0] exp_v, input string name);
        mode = m;
        if (sel == 2) begin
            a16 = a; b16 = b; start16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0];
            if (sel == 1) startu = 1'b1; else start8 = 1'b1;
        end
        step();
        start8 = 1'b0; startu = 1'b0; start16 = 1'b0;
        wait_done(sel, exp_k, exp_v, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        vecs[0] = '{8'h81, 8'h13, 1'b0, 16'h0993, "u 81*13"};
        vecs[1] = '{8'hF0, 8'h35, 1'b0, 16'h31B0, "u F0*35"};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u FF*FF"};
        vecs[3] = '{8'h00, 8'h55, 1'b0, 16'h0000, "u 00*55"};
        vecs[4] = '{8'hF0, 8'h35, 1'b1, 16'hFCB0, "s F0*35"};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 16'h4000, "s 80*80"};
        vecs[6] = '{8'h80, 8'h01, 1'b1, 16'hFF80, "s 80*01"};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s FF*FF"};
        vecs[8] = '{8'h7F, 8'h80, 1'b1, 16'hC080, "s 7F*80"};
        vecs[9] = '{8'h05, 8'h07, 1'b1, 16'h0023, "s 05*07"};

        // Reset held with start asserted, then first capture right after release.
        #2;
        rst = 1'b0; start8 = 1'b1; a8 = 8'h81; b8 = 8'h13; mode = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset d_out", {16'h0000, dout8}, 32'd0);
            check("reset done", {31'd0, done8}, 32'd0);
            check("reset busy", {31'd0, busy8}, 32'd0);
            step();
        end
        rst = 1'b1;
        check("post-reset busy", {31'd0, busy8}, 32'd0);
        step();
        check("first capture busy", {31'd0, busy8}, 32'd1);
        start8 = 1'b0;
        wait_done(0, 9, 32'h0993, "first op");
        a8 = 8'hF0;
        step(); step(); step();
        check("d_out hold", {16'h0000, dout8}, 32'h0993);

        for (int i = 0; i < 10; i++) begin
            run_op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].m, 9, {16'h0000, vecs[i].exp}, vecs[i].name);
        end

        // Held start: mid-run operand change is ignored, then auto-repeat picks it up.
        mode = 1'b0; a8 = 8'h81; b8 = 8'h13; start8 = 1'b1;
        step();
        a8 = 8'hF0; b8 = 8'h35;
        wait_done(0, 9, 32'h0993, "held first");
        wait_done(0, 10, 32'h31B0, "held repeat");
        start8 = 1'b0;
        step(); step();

        run_op(1, 16'h00F0, 16'h0035, 1'b1, 9, 32'h000031B0, "unsigned-only F0*35");
        run_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 17, 32'hFFFE0001, "w16 FFFF*FFFF");

        // Reset asserted between edges partway through an operation.
        mode = 1'b0; a8 = 8'h05; b8 = 8'h07; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort d_out", {16'h0000, dout8}, 32'd0);
        check("abort done", {31'd0, done8}, 32'd0);
        check("abort busy", {31'd0, busy8}, 32'd0);
        step();
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done8) n_done++;
        end
        check("abort no done", n_done, 32'd0);
        run_op(0, 16'h007F, 16'h007F, 1'b0, 9, 32'h3F01, "after abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
